// File: rtl/im_loader.sv
// Instruction-memory loader: receives a framed big-endian byte stream,
// writes 16-bit words to IM at sequential addresses and holds the CPU in
// reset until a complete, legal image has been loaded.
// Optional feature macro: IM_LOADER_CKSUM_EN (adds a trailing 16-bit
// modulo-2^16 checksum of the data words, checked before releasing the CPU).
module im_loader #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DAT_HI,
    S_DAT_LO,
`ifdef IM_LOADER_CKSUM_EN
    S_CK_HI,
    S_CK_LO,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t              state;
  logic [BYTE_W-1:0]   hi_byte;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    idx;
`ifdef IM_LOADER_CKSUM_EN
  logic [WORD_W-1:0]   sum;
`endif

  logic                accept;
  logic [CNT_W-1:0]    hdr;
  logic [WORD_W-1:0]   word;
  logic                last_word;

  // Byte acceptance window is a pure function of state.
  always_comb begin
    rx_ready = 1'b0;
    case (state)
      S_CNT_HI, S_CNT_LO, S_DAT_HI, S_DAT_LO: rx_ready = 1'b1;
`ifdef IM_LOADER_CKSUM_EN
      S_CK_HI, S_CK_LO:                       rx_ready = 1'b1;
`endif
      default:                                rx_ready = 1'b0;
    endcase
  end

  // Helpers: handshake, assembled header/word, last-word detect.
  always_comb begin
    accept    = rx_valid && rx_ready;
    hdr       = {cnt[CNT_W-1:BYTE_W], rx_data};
    word      = {hi_byte, rx_data};
    last_word = ((idx + CNT_W'(1)) == cnt);
  end

  // Loader FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hi_byte   <= '0;
      cnt       <= '0;
      idx       <= '0;
`ifdef IM_LOADER_CKSUM_EN
      sum       <= '0;
`endif
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_CNT_HI;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_rst_n <= 1'b0;
            idx       <= '0;
`ifdef IM_LOADER_CKSUM_EN
            sum       <= '0;
`endif
          end
        end
        S_CNT_HI: begin
          if (accept) begin
            cnt   <= {rx_data, cnt[BYTE_W-1:0]};
            state <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (accept) begin
            cnt <= hdr;
            if (32'(hdr) > MAX_WORDS) begin
              state <= S_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else if (hdr == '0) begin
`ifdef IM_LOADER_CKSUM_EN
              state <= S_CK_HI;
`else
              state     <= S_DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              cpu_rst_n <= 1'b1;
`endif
            end else begin
              state <= S_DAT_HI;
            end
          end
        end
        S_DAT_HI: begin
          if (accept) begin
            hi_byte <= rx_data;
            state   <= S_DAT_LO;
          end
        end
        S_DAT_LO: begin
          if (accept) begin
            wr_en   <= 1'b1;
            wr_data <= word;
            wr_addr <= ADDR_W'(idx);
            idx     <= idx + CNT_W'(1);
`ifdef IM_LOADER_CKSUM_EN
            sum     <= sum + word;
`endif
            if (last_word) begin
`ifdef IM_LOADER_CKSUM_EN
              state <= S_CK_HI;
`else
              state     <= S_DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              cpu_rst_n <= 1'b1;
`endif
            end else begin
              state <= S_DAT_HI;
            end
          end
        end
`ifdef IM_LOADER_CKSUM_EN
        S_CK_HI: begin
          if (accept) begin
            hi_byte <= rx_data;
            state   <= S_CK_LO;
          end
        end
        S_CK_LO: begin
          if (accept) begin
            busy <= 1'b0;
            if (word == sum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected IM writes are queued as bytes
// are driven and matched against wr_en pulses; status is checked per load.
module tb_im_loader;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;

  logic [31:0] sb[$];
  logic [15:0] words[$];

  im_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_rst_n(cpu_rst_n),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor: every wr_en pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check("wr_unexpected", {16'(wr_addr), wr_data}, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[31:16]));
        check("wr_data", 32'(wr_data), 32'(e[15:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int n = 0;
    if (rnd) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output int lat);
    lat = 0;
    @(negedge clk);
    while (!(done || err) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) check("end_timeout", 32'(done || err), 32'd1);
  endtask

  // Full frame from `words` with header n; checksum appended when built in.
  task automatic load(input int unsigned n, input bit rnd, input bit mid_start,
                      input bit bad_ck, input bit exp_ok, input string name);
    logic [15:0] s = '0;
    int lat;
    wr_cnt = 0;
    pulse_start();
    check({name, "_cpu_rst_low"}, 32'(cpu_rst_n), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd1);
    send_byte(8'(n >> 8), rnd);
    send_byte(8'(n), rnd);
    foreach (words[i]) begin
      if (mid_start && i == 1) pulse_start();
      sb.push_back({16'(i), words[i]});
      s = s + words[i];
      send_byte(words[i][15:8], rnd);
      send_byte(words[i][7:0], rnd);
    end
`ifdef IM_LOADER_CKSUM_EN
    if (n <= MAX_WORDS) begin
      if (bad_ck) s = s ^ 16'h0001;
      send_byte(s[15:8], rnd);
      send_byte(s[7:0], rnd);
    end
`else
    if (bad_ck) s = '0;
`endif
    wait_end(lat);
    check({name, "_latency"}, 32'(lat), 32'd0);
    @(negedge clk);
    check({name, "_done"}, 32'(done), 32'(exp_ok));
    check({name, "_err"}, 32'(err), 32'(!exp_ok));
    check({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_ok));
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_writes"}, 32'(wr_cnt), 32'(words.size()));
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_wr_en"}, 32'(wr_en), 32'd0);
    check({name, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({name, "_wr_data"}, 32'(wr_data), 32'd0);
    check({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
    check({name, "_rx_ready"}, 32'(rx_ready), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic two-word image.
    words = '{16'h1234, 16'hABCD};
    load(2, 1'b0, 1'b0, 1'b0, 1'b1, "basic");

    // Oversized header: error right after count lo, no writes.
    words = {};
    load(MAX_WORDS + 1, 1'b0, 1'b0, 1'b0, 1'b0, "too_big");

    // Empty image.
    words = {};
    load(0, 1'b0, 1'b0, 1'b0, 1'b1, "empty");

    // Checksum wrap case, good then (when built in) bad.
    words = '{16'h0001, 16'hFFFF};
    load(2, 1'b0, 1'b0, 1'b0, 1'b1, "ck_good");
`ifdef IM_LOADER_CKSUM_EN
    load(2, 1'b0, 1'b0, 1'b1, 1'b0, "ck_bad");
`endif

    // Random valid gaps plus an ignored start mid-load.
    words = {};
    for (int i = 0; i < 6; i++) words.push_back(16'($urandom()));
    load(6, 1'b1, 1'b1, 1'b0, 1'b1, "rnd_gap");

    // Reset after the third data byte, then a clean reload.
    words = '{16'h5A5A, 16'hC3C3, 16'h0F0F};
    wr_cnt = 0;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    sb.push_back({16'd0, words[0]});
    send_byte(words[0][15:8], 1'b0);
    send_byte(words[0][7:0], 1'b0);
    send_byte(words[1][15:8], 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_writes", 32'(wr_cnt), 32'd1);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);
    check("midrst_idle_cpu", 32'(cpu_rst_n), 32'd0);
    load(3, 1'b0, 1'b0, 1'b0, 1'b1, "reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
